// File: rtl/mmr_irq_ctrl.sv
// Interrupt controller on the MMR window: pending/mask/trigger registers and the level irq to the PS.
// Optional macro MMR_IRQ_HOLDOFF_EN adds a HOLDOFF register (0x044) and a post-deassert hold state.
module mmr_irq_ctrl #(
  parameter int NSRC       = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  reg_wr_en,
  input  logic                  reg_rd_en,
  input  logic [ADDR_WIDTH-1:0] reg_addr,
  input  logic [DATA_WIDTH-1:0] reg_wdata,
  output logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  reg_rvalid,
  output logic                  reg_hit,
  input  logic [NSRC-1:0]       irq_src,
  output logic                  irq
);

  localparam logic [ADDR_WIDTH-1:0] A_TER  = ADDR_WIDTH'(12'h040);
  localparam logic [ADDR_WIDTH-1:0] A_HOLD = ADDR_WIDTH'(12'h044);
  localparam logic [ADDR_WIDTH-1:0] A_TSR  = ADDR_WIDTH'(12'h04c);
  localparam logic [ADDR_WIDTH-1:0] A_IER  = ADDR_WIDTH'(12'h050);
  localparam logic [ADDR_WIDTH-1:0] A_IDR  = ADDR_WIDTH'(12'h054);
  localparam logic [ADDR_WIDTH-1:0] A_IMR  = ADDR_WIDTH'(12'h058);
  localparam logic [ADDR_WIDTH-1:0] A_ISR  = ADDR_WIDTH'(12'h05c);

`ifdef MMR_IRQ_HOLDOFF_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ASSERT = 2'd1, ST_HOLD = 2'd2} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ASSERT = 2'd1} state_e;
`endif

  state_e                  state_q, state_d;
  logic [NSRC-1:0]         ter_q, ter_d;
  logic [NSRC-1:0]         imr_q, imr_d;
  logic [NSRC-1:0]         isr_q, isr_d;
  logic [NSRC-1:0]         prev_q;
  logic                    irq_q, irq_d;
  logic                    rvalid_q, rvalid_d;
  logic                    hit_q, hit_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0]   addr_s;
  logic [NSRC-1:0]         wd_s;
  logic                    sel_ter_s, sel_hold_s, sel_tsr_s, sel_ier_s;
  logic                    sel_idr_s, sel_imr_s, sel_isr_s, claim_s;
  logic                    pend_s;
  logic                    unused_s;

`ifdef MMR_IRQ_HOLDOFF_EN
  logic [15:0]             holdoff_q, holdoff_d;
  logic [15:0]             cnt_q, cnt_d;
`endif

  assign addr_s   = {reg_addr[ADDR_WIDTH-1:2], 2'b00};
  assign wd_s     = reg_wdata[NSRC-1:0];
  assign unused_s = ^{reg_wdata, reg_addr[1:0]};
  assign pend_s   = |(isr_q & imr_q);

  always_comb begin
    sel_ter_s = (addr_s == A_TER);
    sel_tsr_s = (addr_s == A_TSR);
    sel_ier_s = (addr_s == A_IER);
    sel_idr_s = (addr_s == A_IDR);
    sel_imr_s = (addr_s == A_IMR);
    sel_isr_s = (addr_s == A_ISR);
`ifdef MMR_IRQ_HOLDOFF_EN
    sel_hold_s = (addr_s == A_HOLD);
`else
    sel_hold_s = 1'b0;
`endif
    claim_s = sel_ter_s | sel_hold_s | sel_tsr_s | sel_ier_s |
              sel_idr_s | sel_imr_s | sel_isr_s;
  end

  // Register file next state; a hardware/TSR set in the same cycle as a W1C wins.
  always_comb begin
    logic [NSRC-1:0] hw_set, sw_set, clr;
    hw_set = (ter_q & irq_src & ~prev_q) | (~ter_q & irq_src);
    sw_set = (reg_wr_en && sel_tsr_s) ? wd_s : {NSRC{1'b0}};
    clr    = (reg_wr_en && sel_isr_s) ? wd_s : {NSRC{1'b0}};
    isr_d  = (isr_q & ~clr) | hw_set | sw_set;
    ter_d  = (reg_wr_en && sel_ter_s) ? wd_s : ter_q;
    if (reg_wr_en && sel_ier_s) begin
      imr_d = imr_q | wd_s;
    end else if (reg_wr_en && sel_idr_s) begin
      imr_d = imr_q & ~wd_s;
    end else begin
      imr_d = imr_q;
    end
`ifdef MMR_IRQ_HOLDOFF_EN
    holdoff_d = (reg_wr_en && sel_hold_s) ? reg_wdata[15:0] : holdoff_q;
`endif
  end

  always_comb begin
    rdata_d  = {DATA_WIDTH{1'b0}};
    rvalid_d = reg_rd_en && claim_s;
    hit_d    = (reg_rd_en || reg_wr_en) && claim_s;
    if (rvalid_d) begin
      if (sel_ter_s) begin
        rdata_d = DATA_WIDTH'(ter_q);
      end else if (sel_imr_s) begin
        rdata_d = DATA_WIDTH'(imr_q);
      end else if (sel_isr_s) begin
        rdata_d = DATA_WIDTH'(isr_q);
`ifdef MMR_IRQ_HOLDOFF_EN
      end else if (sel_hold_s) begin
        rdata_d = DATA_WIDTH'(holdoff_q);
`endif
      end else begin
        rdata_d = {DATA_WIDTH{1'b0}};
      end
    end else begin
      rdata_d = {DATA_WIDTH{1'b0}};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ter_q    <= {NSRC{1'b0}};
      imr_q    <= {NSRC{1'b0}};
      isr_q    <= {NSRC{1'b0}};
      prev_q   <= {NSRC{1'b0}};
      rvalid_q <= 1'b0;
      hit_q    <= 1'b0;
      rdata_q  <= {DATA_WIDTH{1'b0}};
`ifdef MMR_IRQ_HOLDOFF_EN
      holdoff_q <= 16'd0;
`endif
    end else begin
      ter_q    <= ter_d;
      imr_q    <= imr_d;
      isr_q    <= isr_d;
      prev_q   <= irq_src;
      rvalid_q <= rvalid_d;
      hit_q    <= hit_d;
      rdata_q  <= rdata_d;
`ifdef MMR_IRQ_HOLDOFF_EN
      holdoff_q <= holdoff_d;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
`ifdef MMR_IRQ_HOLDOFF_EN
      cnt_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MMR_IRQ_HOLDOFF_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // HOLD lasts HOLDOFF cycles; HOLDOFF=0 skips it entirely.
  always_comb begin
    state_d = state_q;
`ifdef MMR_IRQ_HOLDOFF_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pend_s) state_d = ST_ASSERT;
        else        state_d = ST_IDLE;
      end
      ST_ASSERT: begin
`ifdef MMR_IRQ_HOLDOFF_EN
        if (pend_s) begin
          state_d = ST_ASSERT;
        end else if (holdoff_q != 16'd0) begin
          state_d = ST_HOLD;
          cnt_d   = holdoff_q;
        end else begin
          state_d = ST_IDLE;
        end
`else
        if (pend_s) state_d = ST_ASSERT;
        else        state_d = ST_IDLE;
`endif
      end
`ifdef MMR_IRQ_HOLDOFF_EN
      ST_HOLD: begin
        if (cnt_q <= 16'd1) begin
          state_d = pend_s ? ST_ASSERT : ST_IDLE;
          cnt_d   = 16'd0;
        end else begin
          state_d = ST_HOLD;
          cnt_d   = cnt_q - 16'd1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    irq_d = (state_d == ST_ASSERT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq        = irq_q;
  assign reg_rvalid = rvalid_q;
  assign reg_hit    = hit_q;
  assign reg_rdata  = rdata_q;

endmodule

// File: doc/mmr_irq_ctrl.md
Name: mmr_irq_ctrl

Overview:
- Interrupt controller behind the MMR register window.
- Owns the interrupt registers: TER 0x040, TSR 0x04c, IER 0x050, IDR 0x054, IMR 0x058, ISR 0x05c.
- Latches per-source events from the datapath into pending status, masks them, and drives the single level interrupt line to the PS.
- The MMR decoder forwards every access; this block claims only its own offsets and reports a hit.

Parameters:
- NSRC, 8: number of interrupt sources (1..32); bits ≥NSRC read 0 and ignore writes.
- ADDR_WIDTH, 8: MMR offset width, 256-byte window.
- DATA_WIDTH, 32: register width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- reg_wr_en  in  1  write strobe, one cycle per access.
- reg_rd_en  in  1  read strobe; never asserted together with reg_wr_en.
- reg_addr  in  ADDR_WIDTH  byte offset; bits [1:0] ignored.
- reg_wdata  in  DATA_WIDTH  write data.
- reg_rdata  out  DATA_WIDTH  read data, valid when reg_rvalid=1.
- reg_rvalid  out  1  read response pulse.
- reg_hit  out  1  registered; 1 when the strobed offset belongs to this block.
- irq_src  in  NSRC  datapath event inputs, synchronous to clock.
- irq  out  1  level interrupt to PS.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0. ISR, IMR, TER, prev-src 0. FSM in IDLE.
- TER (RW): bit=1 selects edge mode, so a rising edge of irq_src sets ISR. Bit=0 selects level mode, so ISR is set every cycle irq_src=1.
- TSR (WO): writing 1 sets ISR bits (software trigger). Reads return 0.
- IER (WO): IMR |= wdata. Reads return 0.
- IDR (WO): IMR &= ~wdata. Reads return 0.
- IMR (RO): bit=1 means the source is enabled. Writes are ignored but still hit.
- ISR (R/W1C): reads return raw pending bits, independent of IMR. Writing 1 clears a bit.
- Simultaneous events on one bit: a hardware or TSR set in the same cycle as a W1C leaves the bit set (set wins).
- Read timing: 1-cycle latency. reg_rvalid and reg_rdata are registered from the cycle of reg_rd_en. reg_rdata returns to 0 when reg_rvalid=0.
- Non-claimed offsets: reg_hit=0, reg_rvalid=0, no state change.
- Edge detection: prev-src register updates every cycle regardless of TER.
- FSM:
  - IDLE: irq=0. When |(ISR&IMR) → ASSERT next cycle.
  - ASSERT: irq=1. When (ISR&IMR)==0 → IDLE next cycle.
- Masking: an IDR write that masks all pending bits deasserts irq on the following cycle. ISR is retained, and an IER write re-asserts irq.
- Latency: irq_src event to irq=1 is 2 cycles (ISR latch, then FSM).
- Reset mid-operation: immediate async clear. A pulse on irq_src during reset is lost.

Optional Feature:
- Macro: MMR_IRQ_HOLDOFF_EN.
- With the macro:
  - Adds HOLDOFF register (RW, 16-bit, reset 0) at offset 0x044.
  - Adds FSM state HOLD.
  - ASSERT→HOLD when (ISR&IMR) becomes 0: counter loads HOLDOFF and irq=0.
  - In HOLD the counter decrements each cycle. At 0 → IDLE, and → ASSERT immediately if pending.
  - Pending bits accumulate in ISR during HOLD without raising irq.
  - HOLDOFF=0 behaves exactly as the non-macro design.
  - A write to HOLDOFF during HOLD does not affect the running count.
- Without the macro: offset 0x044 is unclaimed (reg_hit=0), and there is no HOLD state.

Test Plan:
- Level source: TER=0, IER←0x01, irq_src[0] high for 1 cycle → ISR=0x01 after 1 cycle, irq=1 after 2. Write ISR←0x01 → irq=0 two cycles later.
- Edge source: TER=0x02, IER←0x02, irq_src[1] held high 10 cycles → ISR[1] set once. W1C while still high → stays 0 until next rising edge.
- Set/clear collision: TER=0, irq_src[2]=1 in the same cycle as an ISR←0x04 write → ISR[2]=1 remains and irq stays 1.
- Masking: ISR=0x08, IMR=0 → irq=0. IER←0x08 → irq=1 two cycles later. IDR←0x08 → irq=0, and an ISR read returns 0x08.
- TSR/readback: TSR←0x30 with IMR=0x10 → read ISR=0x30 with reg_rvalid one cycle after reg_rd_en and irq=1. Read of TSR/IER/IDR → 0. Read of 0x010 → reg_hit=0, reg_rvalid=0.
- (MMR_IRQ_HOLDOFF_EN) HOLDOFF=5: clear ISR, then a new event arrives 1 cycle later → irq stays 0 for 5 cycles after deassertion, then asserts. Assert reset during HOLD → irq=0 and FSM in IDLE immediately.
